// File: rtl/hash_light_chain_if.sv
// Block-in / digest-out handshake bundle for hash_light_chain.
interface hash_light_chain_if #(
  parameter int NB = 4
);
  logic            blk_valid;
  logic            blk_ready;
  logic [8*NB-1:0] blk_data;
  logic            blk_last;
  logic [8*NB-1:0] iv;
  logic            dig_valid;
  logic            dig_ready;
  logic [8*NB-1:0] digest;

  modport master (
    output blk_valid, blk_data, blk_last, iv, dig_ready,
    input  blk_ready, dig_valid, digest
  );

  modport slave (
    input  blk_valid, blk_data, blk_last, iv, dig_ready,
    output blk_ready, dig_valid, digest
  );
endinterface

// File: rtl/hash_light_chain.sv
// Multi-block Davies-Meyer chained light hash: NROUNDS byte-wise rounds per
// NB-byte block, one round per cycle, registered digest on a valid/ready port.
module hash_light_chain #(
  parameter int NB      = 4,
  parameter int NROUNDS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort_i,
  output logic              busy_o,
  hash_light_chain_if.slave bus
);
  localparam int            RW    = (NROUNDS > 1) ? $clog2(NROUNDS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(NROUNDS - 1);

  typedef enum logic [1:0] {IDLE, ROUND, WAIT, OUT} state_e;

  state_e          state_q, state_d;
  logic [8*NB-1:0] hChain_q, hChain_d;
  logic [8*NB-1:0] sRound_q, sRound_d;
  logic [8*NB-1:0] ivReg_q, ivReg_d;
  logic [8*NB-1:0] digest_q, digest_d;
  logic [RW-1:0]   rCnt_q, rCnt_d;
  logic            lastFlag_q, lastFlag_d;
  logic [8*NB-1:0] roundOut, hNew, digestNew;

  // y[i] = rotl3(x[i] + x[i+1]) ^ rc ^ i, byte indices wrapping mod NB
  function automatic logic [8*NB-1:0] roundFn(input logic [8*NB-1:0] x,
                                              input logic [7:0]      rc);
    logic [8*NB-1:0] y;
    logic [7:0]      sum;
    y = '0;
    for (int i = 0; i < NB; i++) begin
      sum = x[8*i +: 8] + x[8*((i + 1) % NB) +: 8];
      y[8*i +: 8] = {sum[4:0], sum[7:5]} ^ rc ^ 8'(i);
    end
    return y;
  endfunction

  always_comb begin
    roundOut  = roundFn(sRound_q, 8'(rCnt_q));
    hNew      = roundOut ^ hChain_q;
    digestNew = '0;
    for (int i = 0; i < NB; i++) begin
      digestNew[8*i +: 8] = hNew[8*i +: 8] ^ ivReg_q[8*(NB-1-i) +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, WAIT: if (bus.blk_valid) state_d = ROUND;
        ROUND:      if (rCnt_q == RLAST) state_d = lastFlag_q ? OUT : WAIT;
        OUT:        if (bus.dig_ready) state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.blk_ready = (state_q == IDLE) || (state_q == WAIT);
    bus.dig_valid = (state_q == OUT);
    bus.digest    = digest_q;
    busy_o        = (state_q != IDLE);
  end

  // Abort wins over any acceptance; H, IVR and digest survive it.
  always_comb begin
    hChain_d   = hChain_q;
    sRound_d   = sRound_q;
    ivReg_d    = ivReg_q;
    digest_d   = digest_q;
    rCnt_d     = rCnt_q;
    lastFlag_d = lastFlag_q;
    if (abort_i) begin
      sRound_d = '0;
      rCnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.blk_valid) begin
            ivReg_d    = bus.iv;
            hChain_d   = bus.iv;
            sRound_d   = bus.iv ^ bus.blk_data;
            lastFlag_d = bus.blk_last;
            rCnt_d     = '0;
          end
        end
        WAIT: begin
          if (bus.blk_valid) begin
            sRound_d   = hChain_q ^ bus.blk_data;
            lastFlag_d = bus.blk_last;
            rCnt_d     = '0;
          end
        end
        ROUND: begin
          sRound_d = roundOut;
          rCnt_d   = rCnt_q + RW'(1);
          if (rCnt_q == RLAST) begin
            rCnt_d   = '0;
            hChain_d = hNew;
            if (lastFlag_q) digest_d = digestNew;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hChain_q   <= '0;
      sRound_q   <= '0;
      ivReg_q    <= '0;
      digest_q   <= '0;
      rCnt_q     <= '0;
      lastFlag_q <= 1'b0;
    end else begin
      hChain_q   <= hChain_d;
      sRound_q   <= sRound_d;
      ivReg_q    <= ivReg_d;
      digest_q   <= digest_d;
      rCnt_q     <= rCnt_d;
      lastFlag_q <= lastFlag_d;
    end
  end
endmodule

// File: tb/tb_hash_light_chain.sv
// Directed bench for hash_light_chain: three instances (NB/NROUNDS = 4/1,
// 4/24, 8/3) share one generic driver selected by 'sel'.
module tb_hash_light_chain;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        vld, lastIn, digRdy, abortIn;
  logic [63:0] dataIn, ivIn;
  logic        blkRdy, digValid, busy;
  logic [63:0] digOut;
  logic        busyA, busyB, busyC;

  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  hash_light_chain_if #(.NB(4)) busA ();
  hash_light_chain_if #(.NB(4)) busB ();
  hash_light_chain_if #(.NB(8)) busC ();

  assign busA.blk_valid = vld && (sel == 2'd0);
  assign busA.blk_data  = dataIn[31:0];
  assign busA.blk_last  = lastIn;
  assign busA.iv        = ivIn[31:0];
  assign busA.dig_ready = digRdy && (sel == 2'd0);
  assign busB.blk_valid = vld && (sel == 2'd1);
  assign busB.blk_data  = dataIn[31:0];
  assign busB.blk_last  = lastIn;
  assign busB.iv        = ivIn[31:0];
  assign busB.dig_ready = digRdy && (sel == 2'd1);
  assign busC.blk_valid = vld && (sel == 2'd2);
  assign busC.blk_data  = dataIn;
  assign busC.blk_last  = lastIn;
  assign busC.iv        = ivIn;
  assign busC.dig_ready = digRdy && (sel == 2'd2);

  hash_light_chain #(.NB(4), .NROUNDS(1)) dutA (
    .clk(clk), .rst(rst), .abort_i(abortIn && (sel == 2'd0)), .busy_o(busyA), .bus(busA));
  hash_light_chain #(.NB(4), .NROUNDS(24)) dutB (
    .clk(clk), .rst(rst), .abort_i(abortIn && (sel == 2'd1)), .busy_o(busyB), .bus(busB));
  hash_light_chain #(.NB(8), .NROUNDS(3)) dutC (
    .clk(clk), .rst(rst), .abort_i(abortIn && (sel == 2'd2)), .busy_o(busyC), .bus(busC));

  always_comb begin
    case (sel)
      2'd0: begin
        blkRdy = busA.blk_ready; digValid = busA.dig_valid; busy = busyA;
        digOut = {32'h0, busA.digest};
      end
      2'd1: begin
        blkRdy = busB.blk_ready; digValid = busB.dig_valid; busy = busyB;
        digOut = {32'h0, busB.digest};
      end
      default: begin
        blkRdy = busC.blk_ready; digValid = busC.dig_valid; busy = busyC;
        digOut = busC.digest;
      end
    endcase
  end

  typedef struct {
    logic [1:0]       sel;
    int               nblk;
    logic [63:0]      iv;
    logic [2:0][63:0] blk;
    logic [63:0]      expDig;
  } vec_t;

  vec_t        vecs [6];
  logic [63:0] dig;
  int          lat;
  logic        seen;

  function automatic int nbOf(input logic [1:0] s);
    return (s == 2'd2) ? 8 : 4;
  endfunction

  function automatic int nrOf(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 24;
      default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] maskNb(input logic [63:0] x, input int nb);
    return (nb == 8) ? x : {32'h0, x[31:0]};
  endfunction

  function automatic logic [63:0] modelRound(input logic [63:0] x, input int nb, input int rc);
    logic [63:0] y;
    logic [7:0]  t, rb, ib;
    y  = '0;
    rb = rc[7:0];
    for (int i = 0; i < nb; i++) begin
      t  = x[8*i +: 8] + x[8*((i + 1) % nb) +: 8];
      ib = i[7:0];
      y[8*i +: 8] = {t[4:0], t[7:5]} ^ rb ^ ib;
    end
    return y;
  endfunction

  function automatic logic [63:0] modelDigest(input int nb, input int nr, input logic [63:0] iv,
                                              input logic [2:0][63:0] blk, input int nblk);
    logic [63:0] h, s, d;
    h = iv;
    for (int b = 0; b < nblk; b++) begin
      s = h ^ blk[b];
      for (int r = 0; r < nr; r++) s = modelRound(s, nb, r);
      h = s ^ h;
    end
    d = '0;
    for (int i = 0; i < nb; i++) d[8*i +: 8] = h[8*i +: 8] ^ iv[8*(nb-1-i) +: 8];
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Waits for blk_ready while scribbling noise on the inputs, then offers one block.
  task automatic sendBlock(input logic [63:0] d, input logic l, input logic [63:0] ivv);
    int guard = 0;
    while (!blkRdy && guard < 200) begin
      vld    = 1'($urandom);
      dataIn = {$urandom, $urandom};
      lastIn = 1'($urandom);
      ivIn   = {$urandom, $urandom};
      @(negedge clk);
      guard++;
    end
    checkOutput("block ready", 64'(blkRdy), 64'd1);
    vld = 1'b1; dataIn = d; lastIn = l; ivIn = ivv;
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, output logic [63:0] d, output int latency);
    for (int b = 0; b < v.nblk; b++) begin
      sendBlock(v.blk[b], (b == v.nblk - 1), (b == 0) ? v.iv : {$urandom, $urandom});
      if (b != v.nblk - 1) checkOutput("ready low in ROUND", 64'(blkRdy), 64'd0);
    end
    latency = 0;
    while (!digValid && latency < 200) begin
      vld    = 1'($urandom);
      dataIn = {$urandom, $urandom};
      lastIn = 1'($urandom);
      ivIn   = {$urandom, $urandom};
      @(negedge clk);
      latency++;
    end
    vld = 1'b0;
    d   = digOut;
  endtask

  task automatic takeDigest();
    digRdy = 1'b1;
    @(negedge clk);
    digRdy = 1'b0;
    checkOutput("after take {dv,busy,rdy}", {61'h0, digValid, busy, blkRdy}, 64'b001);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 2'd0; vld = 1'b0; lastIn = 1'b0; digRdy = 1'b0; abortIn = 1'b0;
    dataIn = '0; ivIn = '0;

    vecs[0] = '{sel: 2'd0, nblk: 1, iv: 64'h0, blk: '0, expDig: 64'h03020100};
    vecs[1] = '{sel: 2'd0, nblk: 2, iv: 64'h0, blk: '0, expDig: 64'h18281808};
    vecs[2] = '{sel: 2'd0, nblk: 1, iv: 64'h11223344, blk: {64'h0, 64'h0, 64'hdeadbeef}, expDig: 64'h0};
    vecs[3] = '{sel: 2'd1, nblk: 1, iv: 64'h01234567, blk: {64'h0, 64'h0, 64'h89abcdef}, expDig: 64'h0};
    vecs[4] = '{sel: 2'd1, nblk: 2, iv: 64'h0, blk: '0, expDig: 64'h0};
    vecs[5] = '{sel: 2'd2, nblk: 3, iv: 64'h0, blk: '0, expDig: 64'h0};
    for (int k = 4; k < 6; k++) begin
      vecs[k].iv = maskNb({$urandom, $urandom}, nbOf(vecs[k].sel));
      for (int b = 0; b < 3; b++) vecs[k].blk[b] = maskNb({$urandom, $urandom}, nbOf(vecs[k].sel));
    end
    for (int k = 2; k < 6; k++) begin
      vecs[k].expDig = modelDigest(nbOf(vecs[k].sel), nrOf(vecs[k].sel), vecs[k].iv,
                                   vecs[k].blk, vecs[k].nblk);
    end

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      checkOutput("reset {rdy,dv,busy}", {61'h0, blkRdy, digValid, busy}, 64'b100);
      checkOutput("reset digest", digOut, 64'h0);
    end
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      sel = vecs[k].sel;
      applyStimulus(vecs[k], dig, lat);
      checkOutput($sformatf("vec%0d digest", k), dig, vecs[k].expDig);
      checkOutput($sformatf("vec%0d latency", k), 64'(lat), 64'(nrOf(vecs[k].sel)));
      takeDigest();
    end

    // Stalled consumer: digest and flags hold while dig_ready stays low.
    sel = 2'd1;
    applyStimulus(vecs[3], dig, lat);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      checkOutput("hold {dv,rdy,busy}", {61'h0, digValid, blkRdy, busy}, 64'b101);
      checkOutput("hold digest", digOut, vecs[3].expDig);
    end
    takeDigest();

    sendBlock(vecs[3].blk[0], 1'b1, vecs[3].iv);
    repeat (10) @(negedge clk);
    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    checkOutput("abort {dv,rdy,busy}", {61'h0, digValid, blkRdy, busy}, 64'b010);
    checkOutput("abort keeps digest", digOut, vecs[3].expDig);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (digValid || busy) seen = 1'b1;
    end
    checkOutput("no digest after abort", 64'(seen), 64'd0);

    vld = 1'b1; dataIn = 64'h55; lastIn = 1'b1; ivIn = 64'h77; abortIn = 1'b1;
    @(negedge clk);
    vld = 1'b0; abortIn = 1'b0;
    checkOutput("abort beats accept", 64'(busy), 64'd0);

    applyStimulus(vecs[3], dig, lat);
    checkOutput("rerun digest", dig, vecs[3].expDig);
    checkOutput("rerun latency", 64'(lat), 64'd24);
    abortIn = 1'b1; digRdy = 1'b1;
    @(negedge clk);
    abortIn = 1'b0; digRdy = 1'b0;
    checkOutput("abort in OUT {dv,busy}", {62'h0, digValid, busy}, 64'b00);
    checkOutput("abort in OUT digest", digOut, vecs[3].expDig);

    // Asynchronous reset: mid-round, in OUT, and with a block on offer.
    sendBlock(vecs[3].blk[0], 1'b1, vecs[3].iv);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst mid-round {dv,rdy,busy}", {61'h0, digValid, blkRdy, busy}, 64'b010);
    checkOutput("rst mid-round digest", digOut, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (digValid || busy || (digOut != 64'h0)) seen = 1'b1;
    end
    checkOutput("no stale digest", 64'(seen), 64'd0);

    applyStimulus(vecs[3], dig, lat);
    checkOutput("pre-rst OUT digest", dig, vecs[3].expDig);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst in OUT {dv,rdy,busy}", {61'h0, digValid, blkRdy, busy}, 64'b010);
    checkOutput("rst in OUT digest", digOut, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    vld = 1'b1; dataIn = 64'h1234; lastIn = 1'b1; rst = 1'b1;
    #1;
    @(negedge clk);
    checkOutput("rst with valid busy", 64'(busy), 64'd0);
    vld = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkOutput("after rst idle {rdy,dv,busy}", {61'h0, blkRdy, digValid, busy}, 64'b100);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
